// File: rtl/lopd_pipe_if.sv
// Valid/ready bundle for lopd_pipe: the word and tag go in, the normalised result comes out.
// The master side drives the input word and the downstream ready; the slave side is the pipe.
interface lopd_pipe_if #(
   parameter int DATA_W = 24,
   parameter int TAG_W  = 4
);
   localparam int POS_W = $clog2(DATA_W);

   logic              i_valid;
   logic              o_ready;
   logic [DATA_W-1:0] i_data;
   logic [TAG_W-1:0]  i_tag;
   logic              o_valid;
   logic              i_ready;
   logic [POS_W-1:0]  o_pos_one;
   logic              o_zero_flag;
   logic [DATA_W-1:0] o_data_norm;
   logic [TAG_W-1:0]  o_tag;

   modport master (
      output i_valid, i_data, i_tag, i_ready,
      input  o_ready, o_valid, o_pos_one, o_zero_flag, o_data_norm, o_tag
   );

   modport slave (
      input  i_valid, i_data, i_tag, i_ready,
      output o_ready, o_valid, o_pos_one, o_zero_flag, o_data_norm, o_tag
   );
endinterface

// File: rtl/lopd_pipe.sv
// Two-stage leading-one detector and left normaliser for the FPU_ADD datapath.
// Stage 1 encodes each 4-bit segment; stage 2 picks the top non-zero segment and shifts.
module lopd_pipe #(
   parameter int DATA_W = 24,
   parameter int TAG_W  = 4
) (
   input logic        i_clk,
   input logic        i_rst_n,
   lopd_pipe_if.slave bus
);
   localparam int POS_W = $clog2(DATA_W);
   localparam int NSEG  = (DATA_W + 3) / 4;
   localparam int PAD_W = NSEG * 4;

   logic              en1, en2;
   logic              v1_q, v1_d, v2_q, v2_d;
   logic [1:0]        seg_pos_q [NSEG];
   logic [1:0]        seg_pos_d [NSEG];
   logic [NSEG-1:0]   seg_zero_q, seg_zero_d;
   logic [DATA_W-1:0] data1_q, data1_d;
   logic [TAG_W-1:0]  tag1_q, tag1_d;
   logic [POS_W-1:0]  pos_q, pos_d, pos_full;
   logic              zero_q, zero_d;
   logic [DATA_W-1:0] norm_q, norm_d;
   logic [TAG_W-1:0]  tag2_q, tag2_d;
   logic [PAD_W-1:0]  padded;
   logic [3:0]        nib;

   always_comb begin
      en2 = ~v2_q | bus.i_ready;
      en1 = ~v1_q | en2;
   end

   // The padding sits below the LSB, so it can never hold the leading one.
   always_comb begin
      padded                      = '0;
      padded[PAD_W-1 -: DATA_W]   = bus.i_data;
      nib                         = '0;
      v1_d                        = v1_q;
      data1_d                     = data1_q;
      tag1_d                      = tag1_q;
      seg_zero_d                  = seg_zero_q;
      for (int s = 0; s < NSEG; s++) begin
         seg_pos_d[s] = seg_pos_q[s];
      end
      if (en1) begin
         v1_d    = bus.i_valid;
         data1_d = bus.i_data;
         tag1_d  = bus.i_tag;
         for (int s = 0; s < NSEG; s++) begin
            nib           = padded[PAD_W-1-4*s -: 4];
            seg_zero_d[s] = (nib == 4'b0000);
            casez (nib)
               4'b1???: seg_pos_d[s] = 2'd0;
               4'b01??: seg_pos_d[s] = 2'd1;
               4'b001?: seg_pos_d[s] = 2'd2;
               4'b0001: seg_pos_d[s] = 2'd3;
               default: seg_pos_d[s] = 2'd0;
            endcase
         end
      end
   end

   // Walking from the bottom segment upward leaves the lowest non-zero index as the winner.
   always_comb begin
      pos_full = '0;
      for (int s = NSEG - 1; s >= 0; s--) begin
         if (!seg_zero_q[s]) begin
            pos_full = POS_W'(4 * s) + POS_W'(seg_pos_q[s]);
         end
      end
      v2_d   = v2_q;
      pos_d  = pos_q;
      zero_d = zero_q;
      norm_d = norm_q;
      tag2_d = tag2_q;
      if (en2) begin
         v2_d   = v1_q;
         pos_d  = pos_full;
         zero_d = &seg_zero_q;
         norm_d = data1_q << pos_full;
         tag2_d = tag1_q;
      end
   end

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         v1_q       <= 1'b0;
         v2_q       <= 1'b0;
         seg_zero_q <= '0;
         data1_q    <= '0;
         tag1_q     <= '0;
         pos_q      <= '0;
         zero_q     <= 1'b0;
         norm_q     <= '0;
         tag2_q     <= '0;
         for (int s = 0; s < NSEG; s++) begin
            seg_pos_q[s] <= 2'd0;
         end
      end else begin
         v1_q       <= v1_d;
         v2_q       <= v2_d;
         seg_zero_q <= seg_zero_d;
         data1_q    <= data1_d;
         tag1_q     <= tag1_d;
         pos_q      <= pos_d;
         zero_q     <= zero_d;
         norm_q     <= norm_d;
         tag2_q     <= tag2_d;
         for (int s = 0; s < NSEG; s++) begin
            seg_pos_q[s] <= seg_pos_d[s];
         end
      end
   end

   assign bus.o_ready     = en1;
   assign bus.o_valid     = v2_q;
   assign bus.o_pos_one   = pos_q;
   assign bus.o_zero_flag = zero_q;
   assign bus.o_data_norm = norm_q;
   assign bus.o_tag       = tag2_q;
endmodule
